// File: rtl/integrator_tdm_sequencer_if.sv
// Bus bundle for the TDM integrator: sample-side inputs and the
// sample-aligned result outputs. Clock and reset stay as plain ports.
interface integrator_tdm_sequencer_if #(
  parameter int DATA_BIT_WIDTH = 5,
  parameter int CH_NUM         = 4
);
  logic                             CLK_I;
  logic [CH_NUM*DATA_BIT_WIDTH-1:0] DATA_I;
  logic [CH_NUM-1:0]                CLR_I;
  logic                             CLK_O;
  logic [CH_NUM*DATA_BIT_WIDTH-1:0] DATA_O;
  logic [CH_NUM-1:0]                OFDET_O;
  logic [CH_NUM-1:0]                UFDET_O;
  logic                             BUSY_O;
  logic                             OVRN_O;

  // Front end / consumer side: drives samples, receives results.
  modport master (
    output CLK_I, DATA_I, CLR_I,
    input  CLK_O, DATA_O, OFDET_O, UFDET_O, BUSY_O, OVRN_O
  );

  // Sequencer side.
  modport slave (
    input  CLK_I, DATA_I, CLR_I,
    output CLK_O, DATA_O, OFDET_O, UFDET_O, BUSY_O, OVRN_O
  );
endinterface

// File: rtl/integrator_tdm_sequencer.sv
// Time-division multiplexed bank of saturating integrators. One signed
// adder is shared by all channels: each sample edge snapshots the inputs,
// walks the channels one per MCLK cycle, then publishes every result at
// once together with a sample-aligned output clock.
module integrator_tdm_sequencer #(
  parameter int DATA_BIT_WIDTH = 5,
  parameter int CH_NUM         = 4,
  parameter int CH_BIT_WIDTH   = 2
) (
  input  logic                        MCLK_I,
  input  logic                        RST_I,
  integrator_tdm_sequencer_if.slave   bus
);

  localparam int W = DATA_BIT_WIDTH;

  localparam logic [W-1:0]            ACC_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]            ACC_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [CH_BIT_WIDTH-1:0] CH_LAST = CH_BIT_WIDTH'(CH_NUM - 1);
  localparam logic [CH_BIT_WIDTH-1:0] CH_ONE  = CH_BIT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    clk_d_q;
  logic [CH_BIT_WIDTH-1:0] ch_q;

  logic [W-1:0]            snap_data_q [CH_NUM];
  logic [CH_NUM-1:0]       snap_clr_q;
  logic [W-1:0]            acc_q       [CH_NUM];
  logic [CH_NUM-1:0]       of_q;
  logic [CH_NUM-1:0]       uf_q;

  logic [CH_NUM*W-1:0]     data_o_q;
  logic [CH_NUM-1:0]       ofdet_q;
  logic [CH_NUM-1:0]       ufdet_q;
  logic                    clk_o_q;
  logic                    busy_q;
  logic                    ovrn_q;

  // Per-channel view of the packed input bus.
  logic [W-1:0]            data_in [CH_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_unpack
      assign data_in[gi] = bus.DATA_I[gi*W +: W];
    end
  endgenerate

  // CLK_I is only sampled; edges are found against its one-cycle delay.
  logic rise_d;
  logic fall_d;
  assign rise_d =  bus.CLK_I & ~clk_d_q;
  assign fall_d = ~bus.CLK_I &  clk_d_q;

  // Shared datapath: the channel selected by ch_q.
  logic [W-1:0] sel_acc;
  logic [W-1:0] sel_in;
  logic         sel_clr;
  logic [W:0]   sum_d;
  logic [W-1:0] acc_d;
  logic         of_d;
  logic         uf_d;

  assign sel_acc = acc_q[ch_q];
  assign sel_in  = snap_data_q[ch_q];
  assign sel_clr = snap_clr_q[ch_q];
  assign sum_d   = {sel_acc[W-1], sel_acc} + {sel_in[W-1], sel_in};

  // Saturating add (or clear) for the channel currently being served.
  always_comb begin
    acc_d = sum_d[W-1:0];
    of_d  = 1'b0;
    uf_d  = 1'b0;
    if (sel_clr) begin
      acc_d = '0;
    end else if (sum_d[W:W-1] == 2'b01) begin
      acc_d = ACC_MAX;
      of_d  = 1'b1;
    end else if (sum_d[W:W-1] == 2'b10) begin
      acc_d = ACC_MIN;
      uf_d  = 1'b1;
    end
  end

  // Frame sequencer: snapshot, per-channel update, publish; all outputs registered.
  always_ff @(posedge MCLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q    <= ST_IDLE;
      clk_d_q    <= 1'b1;
      ch_q       <= '0;
      snap_clr_q <= '0;
      of_q       <= '0;
      uf_q       <= '0;
      data_o_q   <= '0;
      ofdet_q    <= '0;
      ufdet_q    <= '0;
      clk_o_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovrn_q     <= 1'b0;
      for (int k = 0; k < CH_NUM; k++) begin
        acc_q[k]       <= '0;
        snap_data_q[k] <= '0;
      end
    end else begin
      clk_d_q <= bus.CLK_I;

      // A fall drops CLK_O; a publish in the same cycle overrides it below.
      if (fall_d) begin
        clk_o_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (rise_d) begin
            for (int k = 0; k < CH_NUM; k++) begin
              snap_data_q[k] <= data_in[k];
            end
            snap_clr_q <= bus.CLR_I;
            ch_q       <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (rise_d) begin
            ovrn_q <= 1'b1;
          end
          acc_q[ch_q] <= acc_d;
          of_q[ch_q]  <= of_d;
          uf_q[ch_q]  <= uf_d;
          if (ch_q == CH_LAST) begin
            state_q <= ST_DONE;
          end else begin
            ch_q <= ch_q + CH_ONE;
          end
        end

        ST_DONE: begin
          if (rise_d) begin
            ovrn_q <= 1'b1;
          end
          for (int k = 0; k < CH_NUM; k++) begin
            data_o_q[k*W +: W] <= acc_q[k];
          end
          ofdet_q <= of_q;
          ufdet_q <= uf_q;
          clk_o_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.DATA_O  = data_o_q;
  assign bus.OFDET_O = ofdet_q;
  assign bus.UFDET_O = ufdet_q;
  assign bus.CLK_O   = clk_o_q;
  assign bus.BUSY_O  = busy_q;
  assign bus.OVRN_O  = ovrn_q;

endmodule
